// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-read FIFO and sends each one
// as an 8N1 UART frame (start bit, 8 data bits LSB first, stop bit).
// The FIFO read data is valid one cycle after the pop, so a one-cycle WAIT
// state sits between the pop and the start bit.
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int CLOCK_FREQ   = 125_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             serial_out,
    output logic             busy,
    output logic             tx_done
);

    // Elaboration-time guards on the configuration.
    generate
        if (WIDTH != 8) begin : g_bad_width
            $error("fifo_uart_tx: WIDTH must be 8");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_divider
            $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Last count of a bit period, and the count just before it (used to
    // register tx_done so it lines up with the final stop-bit cycle).
    localparam logic [CNT_WIDTH-1:0] LAST_CNT     = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] PRE_LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 2);

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_baud_cnt;
    logic [2:0]             r_bit_idx;
    logic [WIDTH-1:0]       r_shift;
    logic                   r_serial;
    logic                   r_busy;
    logic                   r_tx_done;

    logic                   w_rd_en;
    logic                   w_bit_end;

    // Pop only from IDLE, only when data exists, never while in reset.
    assign w_rd_en   = (r_state == S_IDLE) && !fifo_empty && !rst;
    assign w_bit_end = (r_baud_cnt == LAST_CNT);

    assign fifo_rd_en = w_rd_en;
    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign tx_done    = r_tx_done;

    // Frame sequencer: every output is registered and computed for the
    // state being entered, so the line changes exactly on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_serial   <= 1'b1;
                    r_baud_cnt <= '0;
                    if (w_rd_en) begin
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end
                end

                S_WAIT: begin
                    // FIFO data is valid now, one cycle after the pop.
                    r_shift    <= fifo_dout;
                    r_baud_cnt <= '0;
                    r_serial   <= 1'b0;
                    r_state    <= S_START;
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_serial   <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shift    <= r_shift >> 1;
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_serial <= 1'b1;
                            r_state  <= S_STOP;
                        end else begin
                            // Next bit is the one about to land in shift[0].
                            r_serial <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    r_serial <= 1'b1;
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                        if (r_baud_cnt == PRE_LAST_CNT) begin
                            r_tx_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the I/O FIFO.
- Pops bytes from the FIFO read port, one at a time, and serializes each one onto the UART TX line as an 8N1 frame: start bit, 8 data bits LSB first, stop bit.
- Sits between the TX FIFO and the board serial pin.
- Handles the FIFO's registered read latency: dout is valid in the cycle after the rd_en edge.

Parameters:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- WIDTH, 8, data width. Fixed at 8; any other value is a configuration error.
- CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (integer divide), clocks per bit. Must be >= 2.
- CNT_WIDTH, $clog2(CLKS_PER_BIT), width of the baud counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  8  FIFO read data; valid the cycle after a pop.
- fifo_rd_en  out  1  pop request to the FIFO.
- serial_out  out  1  UART TX line; idle high.
- busy  out  1  high in any state other than IDLE.
- tx_done  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (rst high at a posedge):
  - state = IDLE, serial_out = 1, tx_done = 0, busy = 0, baud counter = 0, bit index = 0, shift register = 0.
  - fifo_rd_en = 0 whenever rst is high.
- States: IDLE, WAIT, START, DATA, STOP.
- IDLE:
  - serial_out = 1.
  - fifo_rd_en = !fifo_empty && !rst (combinational). It is never asserted in any other state.
  - If fifo_rd_en is high at the edge: state -> WAIT.
- WAIT (exactly 1 cycle):
  - serial_out = 1.
  - At the exiting edge: shift register <= fifo_dout, baud counter <= 0, state -> START.
- START:
  - serial_out = 0 for exactly CLKS_PER_BIT cycles.
  - Then bit index <= 0, state -> DATA.
- DATA:
  - serial_out = shift[0].
  - Each bit is held exactly CLKS_PER_BIT cycles, then the register shifts right by 1 and bit index increments.
  - After bit 7: state -> STOP.
- STOP:
  - serial_out = 1 for CLKS_PER_BIT cycles.
  - tx_done is high on the final cycle of STOP.
  - Then state -> IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Reset to 0 on every state entry.
- serial_out is driven from a register (glitch-free).
- Timing: the frame is 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- Latency: fifo_empty falling while in IDLE gives rd_en in that same cycle; START begins 2 cycles after the rd_en cycle.
- Back-to-back bytes: the FIFO stays non-empty, and exactly 2 idle-high cycles (IDLE, WAIT) separate consecutive frames.
- Exactly one pop per frame. The FIFO is never popped while empty or mid-frame.
- Boundary conditions:
  - fifo_empty toggling mid-frame is ignored.
  - Reset mid-frame aborts the frame: the line is high the cycle after the reset edge, the popped byte is discarded, and there is no tx_done.
  - busy falls in the same cycle the state returns to IDLE.

Test Plan:
- Reset the bench with CLOCK_FREQ=1000, BAUD_RATE=100 (CLKS_PER_BIT=10), FIFO empty, for 50 cycles -> serial_out=1, fifo_rd_en=0, busy=0, tx_done=0 throughout.
- Push 0xA5 into the FIFO -> exactly one rd_en pulse; 2 cycles later the line carries 0 for 10 cycles, then data bits 1,0,1,0,0,1,0,1 (10 cycles each), then 1 for 10 cycles; tx_done pulses once on frame cycle 100; a bench-side UART receiver decodes 0xA5.
- Push 0x00, 0xFF, 0x3C back-to-back -> three frames decode in order; idle gap between frames is exactly 2 cycles; exactly 3 rd_en pulses; FIFO empty at the end.
- Assert rst for 1 cycle during DATA bit 3 of 0x55 -> serial_out=1 on the next cycle, no tx_done, busy=0; a following push of 0x12 transmits correctly.
- Pulse fifo_empty low/high repeatedly during a frame (FIFO model holding 1 extra byte) -> no rd_en mid-frame; the second byte starts only after STOP completes.
- With FIFO full (32 entries, 0..31) -> all 32 bytes are transmitted in order with no loss or duplication; rd_en is never high while fifo_empty=1.
